cpt_nbits_dec: RTL and testbench



---
 rtl/cpt_pkg.sv | 20 ++
 rtl/cpt_next_dec.sv | 46 ++++
 rtl/cpt_nbits_dec.sv | 71 +++++++
 tb/tb_cpt_nbits_dec.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpt_pkg.sv
// Shared definitions for the cpt_* modulo-N counter family (up and down).
// Holds the edge-select constants and the elaboration helpers for MODULO_VALUE.
package cpt_pkg;

  localparam bit CLK_RISING  = 1'b1;
  localparam bit CLK_FALLING = 1'b0;

  // A modulo is legal when it spans at least two states and fits in width bits.
  function automatic bit modulo_legal(input int unsigned modulo, input int unsigned width);
    longint unsigned cap;
    cap = 64'd1 << width;
    return (modulo >= 32'd2) && (longint'(modulo) <= longint'(cap));
  endfunction

  // Terminal (reload) value; callers slice it to their counter width.
  function automatic int unsigned reload_value(input int unsigned modulo);
    return modulo - 32'd1;
  endfunction

endpackage

// File: rtl/cpt_next_dec.sv
// Next-state logic of the modulo-N down-counter: next Q and next Done.
// Purely combinational; priority is nSet > Load > En.
module cpt_next_dec
  import cpt_pkg::*;
#(
  parameter int unsigned              OUTPUT_SIZE = 4,
  parameter bit                       AUTO_RELOAD = 1'b1,
  parameter logic [OUTPUT_SIZE-1:0]   RELOAD      = '1
) (
  input  logic [OUTPUT_SIZE-1:0] q_i,
  input  logic                   done_i,
  input  logic                   en_i,
  input  logic                   load_i,
  input  logic [OUTPUT_SIZE-1:0] d_i,
  input  logic                   n_set_i,
  output logic [OUTPUT_SIZE-1:0] q_d_o,
  output logic                   done_d_o
);

  localparam int unsigned            ONE_I = 1;
  localparam logic [OUTPUT_SIZE-1:0] ONE   = ONE_I[OUTPUT_SIZE-1:0];

  always_comb begin
    q_d_o    = q_i;
    done_d_o = done_i;
    if (!n_set_i) begin
      q_d_o    = RELOAD;
      done_d_o = 1'b0;
    end else if (load_i) begin
      // Out-of-range loads clamp to the top of the count range.
      q_d_o    = (d_i > RELOAD) ? RELOAD : d_i;
      done_d_o = 1'b0;
    end else if (en_i) begin
      if (q_i != '0) begin
        q_d_o = q_i - ONE;
        if (q_i == ONE) begin
          done_d_o = 1'b1;
        end
      end else if (AUTO_RELOAD) begin
        q_d_o    = RELOAD;
        done_d_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpt_nbits_dec.sv
// Loadable, cascadable modulo-N down-counter with sticky Done flag.
// Holds the registers and async reset; Zero/Borrow are combinational from Q and En.
module cpt_nbits_dec
  import cpt_pkg::*;
#(
  parameter int unsigned OUTPUT_SIZE     = 4,
  parameter int unsigned MODULO_VALUE    = 10,
  parameter bit          AUTO_RELOAD     = 1'b1,
  parameter bit          CLK_ACTIVE_EDGE = CLK_RISING
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic                   nSet,
  input  logic                   Load,
  input  logic [OUTPUT_SIZE-1:0] D,
  input  logic                   En,
  output logic [OUTPUT_SIZE-1:0] Q,
  output logic                   Zero,
  output logic                   Borrow,
  output logic                   Done
);

  if (!modulo_legal(MODULO_VALUE, OUTPUT_SIZE)) begin : g_bad_modulo
    $error("cpt_nbits_dec: MODULO_VALUE must lie in 2..2**OUTPUT_SIZE");
  end

  localparam int unsigned            RELOAD_I = reload_value(MODULO_VALUE);
  localparam logic [OUTPUT_SIZE-1:0] RELOAD   = RELOAD_I[OUTPUT_SIZE-1:0];

  // Single internal clock; the falling-edge variant simply runs on ~Clk.
  logic iClk;
  if (CLK_ACTIVE_EDGE == CLK_RISING) begin : g_clk_rise
    assign iClk = Clk;
  end else begin : g_clk_fall
    assign iClk = ~Clk;
  end

  logic [OUTPUT_SIZE-1:0] q_q, q_d;
  logic                   done_q, done_d;

  cpt_next_dec #(
    .OUTPUT_SIZE (OUTPUT_SIZE),
    .AUTO_RELOAD (AUTO_RELOAD),
    .RELOAD      (RELOAD)
  ) u_next (
    .q_i      (q_q),
    .done_i   (done_q),
    .en_i     (En),
    .load_i   (Load),
    .d_i      (D),
    .n_set_i  (nSet),
    .q_d_o    (q_d),
    .done_d_o (done_d)
  );

  always_ff @(posedge iClk or negedge nReset) begin
    if (!nReset) begin
      q_q    <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      done_q <= done_d;
    end
  end

  assign Q      = q_q;
  assign Done   = done_q;
  assign Zero   = (q_q == '0);
  assign Borrow = En & Zero;

endmodule

// File: tb/tb_cpt_nbits_dec.sv
// Directed bench for cpt_nbits_dec: auto-reload, one-shot, full-range modulo,
// and two-stage cascades on rising and falling clock edges.
module tb_cpt_nbits_dec;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset;

  // Group A: MOD10, auto-reload, rising edge
  logic       a_nset, a_load, a_en;
  logic [3:0] a_d, a_q;
  logic       a_zero, a_borrow, a_done;
  // Group B: MOD10, one-shot
  logic       b_load, b_en;
  logic [3:0] b_d, b_q;
  logic       b_zero, b_borrow, b_done;
  // Group M: MOD16, auto-reload
  logic       m_load, m_en;
  logic [3:0] m_d, m_q;
  logic       m_zero, m_borrow, m_done;
  // Cascade rising (c) and falling (f)
  logic       c_load, f_load;
  logic [3:0] c0_d, c1_d, f0_d, f1_d;
  logic [3:0] c0_q, c1_q, f0_q, f1_q;
  logic       c0_zero, c0_borrow, c0_done, c1_zero, c1_borrow, c1_done;
  logic       f0_zero, f0_borrow, f0_done, f1_zero, f1_borrow, f1_done;

  cpt_nbits_dec #(.OUTPUT_SIZE(4), .MODULO_VALUE(10), .AUTO_RELOAD(1'b1), .CLK_ACTIVE_EDGE(1'b1)) u_a (
    .Clk(clk), .nReset(nreset), .nSet(a_nset), .Load(a_load), .D(a_d), .En(a_en),
    .Q(a_q), .Zero(a_zero), .Borrow(a_borrow), .Done(a_done));

  cpt_nbits_dec #(.OUTPUT_SIZE(4), .MODULO_VALUE(10), .AUTO_RELOAD(1'b0), .CLK_ACTIVE_EDGE(1'b1)) u_b (
    .Clk(clk), .nReset(nreset), .nSet(1'b1), .Load(b_load), .D(b_d), .En(b_en),
    .Q(b_q), .Zero(b_zero), .Borrow(b_borrow), .Done(b_done));

  cpt_nbits_dec #(.OUTPUT_SIZE(4), .MODULO_VALUE(16), .AUTO_RELOAD(1'b1), .CLK_ACTIVE_EDGE(1'b1)) u_m (
    .Clk(clk), .nReset(nreset), .nSet(1'b1), .Load(m_load), .D(m_d), .En(m_en),
    .Q(m_q), .Zero(m_zero), .Borrow(m_borrow), .Done(m_done));

  cpt_nbits_dec #(.OUTPUT_SIZE(4), .MODULO_VALUE(10), .AUTO_RELOAD(1'b1), .CLK_ACTIVE_EDGE(1'b1)) u_c0 (
    .Clk(clk), .nReset(nreset), .nSet(1'b1), .Load(c_load), .D(c0_d), .En(1'b1),
    .Q(c0_q), .Zero(c0_zero), .Borrow(c0_borrow), .Done(c0_done));

  cpt_nbits_dec #(.OUTPUT_SIZE(4), .MODULO_VALUE(10), .AUTO_RELOAD(1'b1), .CLK_ACTIVE_EDGE(1'b1)) u_c1 (
    .Clk(clk), .nReset(nreset), .nSet(1'b1), .Load(c_load), .D(c1_d), .En(c0_borrow),
    .Q(c1_q), .Zero(c1_zero), .Borrow(c1_borrow), .Done(c1_done));

  cpt_nbits_dec #(.OUTPUT_SIZE(4), .MODULO_VALUE(10), .AUTO_RELOAD(1'b1), .CLK_ACTIVE_EDGE(1'b0)) u_f0 (
    .Clk(clk), .nReset(nreset), .nSet(1'b1), .Load(f_load), .D(f0_d), .En(1'b1),
    .Q(f0_q), .Zero(f0_zero), .Borrow(f0_borrow), .Done(f0_done));

  cpt_nbits_dec #(.OUTPUT_SIZE(4), .MODULO_VALUE(10), .AUTO_RELOAD(1'b1), .CLK_ACTIVE_EDGE(1'b0)) u_f1 (
    .Clk(clk), .nReset(nreset), .nSet(1'b1), .Load(f_load), .D(f1_d), .En(f0_borrow),
    .Q(f1_q), .Zero(f1_zero), .Borrow(f1_borrow), .Done(f1_done));

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [W-1:0] pk(input logic [3:0] q, input logic d, input logic z, input logic b);
    return {1'b0, q, d, z, b};
  endfunction

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] exp;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed=%h but no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick_r();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_f();
    @(negedge clk);
    #1;
  endtask

  initial begin
    nreset = 1'b0;
    a_nset = 1'b1; a_load = 1'b0; a_en = 1'b0; a_d = '0;
    b_load = 1'b0; b_en = 1'b0; b_d = '0;
    m_load = 1'b0; m_en = 1'b0; m_d = '0;
    c_load = 1'b0; c0_d = '0; c1_d = '0;
    f_load = 1'b0; f0_d = '0; f1_d = '0;

    // Reset state
    repeat (2) tick_r();
    push(pk(4'd0, 1'b0, 1'b1, 1'b0));
    check("a_reset", pk(a_q, a_done, a_zero, a_borrow));
    nreset = 1'b1;

    // Load 7, then async reset mid-cycle while counting is enabled
    a_load = 1'b1; a_d = 4'd7;
    push(pk(4'd7, 1'b0, 1'b0, 1'b0));
    tick_r();
    check("a_load7", pk(a_q, a_done, a_zero, a_borrow));
    a_load = 1'b0; a_en = 1'b1;
    #3 nreset = 1'b0;
    #2;
    push(pk(4'd0, 1'b0, 1'b1, 1'b1));
    check("a_async_rst", pk(a_q, a_done, a_zero, a_borrow));
    #1 nreset = 1'b1;
    push(pk(4'd9, 1'b1, 1'b0, 1'b0));
    tick_r();
    check("a_rel_reload", pk(a_q, a_done, a_zero, a_borrow));

    // Load and clamp
    a_en = 1'b0; a_load = 1'b1; a_d = 4'd5;
    push(pk(4'd5, 1'b0, 1'b0, 1'b0));
    tick_r();
    check("a_load5", pk(a_q, a_done, a_zero, a_borrow));
    a_d = 4'd12;
    push(pk(4'd9, 1'b0, 1'b0, 1'b0));
    tick_r();
    check("a_clamp12", pk(a_q, a_done, a_zero, a_borrow));
    a_d = 4'd3; a_en = 1'b1;
    push(pk(4'd3, 1'b0, 1'b0, 1'b0));
    tick_r();
    check("a_load_en", pk(a_q, a_done, a_zero, a_borrow));

    // Countdown with auto-reload from 2
    a_en = 1'b0; a_d = 4'd2;
    push(pk(4'd2, 1'b0, 1'b0, 1'b0));
    tick_r();
    check("a_load2", pk(a_q, a_done, a_zero, a_borrow));
    a_load = 1'b0; a_en = 1'b1;
    push(pk(4'd1, 1'b0, 1'b0, 1'b0));
    tick_r();
    check("a_cnt1", pk(a_q, a_done, a_zero, a_borrow));
    push(pk(4'd0, 1'b1, 1'b1, 1'b1));
    tick_r();
    check("a_cnt0", pk(a_q, a_done, a_zero, a_borrow));
    push(pk(4'd9, 1'b1, 1'b0, 1'b0));
    tick_r();
    check("a_cnt9", pk(a_q, a_done, a_zero, a_borrow));
    push(pk(4'd8, 1'b1, 1'b0, 1'b0));
    tick_r();
    check("a_cnt8", pk(a_q, a_done, a_zero, a_borrow));
    a_en = 1'b0;
    push(pk(4'd8, 1'b1, 1'b0, 1'b0));
    tick_r();
    check("a_hold", pk(a_q, a_done, a_zero, a_borrow));

    // Priority: nSet over Load, then Load of 0 clears Done
    a_nset = 1'b0; a_load = 1'b1; a_d = 4'd3;
    push(pk(4'd9, 1'b0, 1'b0, 1'b0));
    tick_r();
    check("a_nset_wins", pk(a_q, a_done, a_zero, a_borrow));
    a_nset = 1'b1; a_d = 4'd0;
    push(pk(4'd0, 1'b0, 1'b1, 1'b0));
    tick_r();
    check("a_load0", pk(a_q, a_done, a_zero, a_borrow));
    a_load = 1'b0;

    // One-shot
    b_load = 1'b1; b_d = 4'd2;
    push(pk(4'd2, 1'b0, 1'b0, 1'b0));
    tick_r();
    check("b_load2", pk(b_q, b_done, b_zero, b_borrow));
    b_load = 1'b0; b_en = 1'b1;
    push(pk(4'd1, 1'b0, 1'b0, 1'b0));
    tick_r();
    check("b_cnt1", pk(b_q, b_done, b_zero, b_borrow));
    for (int i = 0; i < 4; i++) begin
      push(pk(4'd0, 1'b1, 1'b1, 1'b1));
      tick_r();
      check("b_hold0", pk(b_q, b_done, b_zero, b_borrow));
    end
    b_en = 1'b0; b_load = 1'b1; b_d = 4'd4;
    push(pk(4'd4, 1'b0, 1'b0, 1'b0));
    tick_r();
    check("b_load4", pk(b_q, b_done, b_zero, b_borrow));
    b_load = 1'b0;

    // Full-range modulo: reload value is all ones
    m_load = 1'b1; m_d = 4'd15;
    push(pk(4'd15, 1'b0, 1'b0, 1'b0));
    tick_r();
    check("m_load15", pk(m_q, m_done, m_zero, m_borrow));
    m_d = 4'd0;
    push(pk(4'd0, 1'b0, 1'b1, 1'b0));
    tick_r();
    check("m_load0", pk(m_q, m_done, m_zero, m_borrow));
    m_load = 1'b0; m_en = 1'b1;
    #1;
    push(pk(4'd0, 1'b0, 1'b1, 1'b1));
    check("m_borrow_comb", pk(m_q, m_done, m_zero, m_borrow));
    push(pk(4'd15, 1'b1, 1'b0, 1'b0));
    tick_r();
    check("m_reload15", pk(m_q, m_done, m_zero, m_borrow));
    m_en = 1'b0;

    // Rising-edge cascade from 1:0
    c_load = 1'b1; c1_d = 4'd1; c0_d = 4'd0;
    push({4'd1, 4'd0});
    tick_r();
    check("c_load", {c1_q, c0_q});
    c_load = 1'b0;
    push({4'd0, 4'd9});
    tick_r();
    check("c_step1", {c1_q, c0_q});
    push({4'd0, 4'd8});
    tick_r();
    check("c_step2", {c1_q, c0_q});

    // Falling-edge cascade: must only move on negedges
    f_load = 1'b1; f1_d = 4'd1; f0_d = 4'd0;
    push({4'd1, 4'd0});
    tick_f();
    check("f_load", {f1_q, f0_q});
    f_load = 1'b0;
    push({4'd1, 4'd0});
    tick_r();
    check("f_no_rise1", {f1_q, f0_q});
    push({4'd0, 4'd9});
    tick_f();
    check("f_step1", {f1_q, f0_q});
    push({4'd0, 4'd9});
    tick_r();
    check("f_no_rise2", {f1_q, f0_q});
    push({4'd0, 4'd8});
    tick_f();
    check("f_step2", {f1_q, f0_q});

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL sb_drain: leftover=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
